// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of mem_port_arbiter, named from the arbiter's view.
// slave = the arbiter itself; master = the surrounding core and memory.
interface mem_port_arbiter_if;
  logic        imem_req_i;
  logic [31:0] imem_addr_i;
  logic        imem_gnt_o;
  logic        imem_rvalid_o;
  logic [31:0] imem_rdata_o;

  logic        dmem_req_i;
  logic [31:0] dmem_addr_i;
  logic [1:0]  dmem_byte_en_i;
  logic        dmem_wr_i;
  logic [31:0] dmem_wr_data_i;
  logic        dmem_gnt_o;
  logic        dmem_rvalid_o;
  logic [31:0] dmem_rdata_o;

  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [1:0]  mem_byte_en_o;
  logic        mem_wr_o;
  logic [31:0] mem_wr_data_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        resp_err_o;

  modport slave (
    input  imem_req_i, imem_addr_i,
    output imem_gnt_o, imem_rvalid_o, imem_rdata_o,
    input  dmem_req_i, dmem_addr_i, dmem_byte_en_i, dmem_wr_i, dmem_wr_data_i,
    output dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o,
    output mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output resp_err_o
  );

  modport master (
    output imem_req_i, imem_addr_i,
    input  imem_gnt_o, imem_rvalid_o, imem_rdata_o,
    output dmem_req_i, dmem_addr_i, dmem_byte_en_i, dmem_wr_i, dmem_wr_data_i,
    input  dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o,
    input  mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  resp_err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports with in-order response routing.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of dmem priority with starvation guard.
module mem_port_arbiter #(
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          id_q [MAX_OUTST];
  logic          resp_err_q, resp_err_d;

  logic room, contend, imem_wins;
  logic sel_valid, sel_dmem, req, accept, pop, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  assign room    = (count_q < CW'(MAX_OUTST));
  assign contend = bus.imem_req_i & bus.dmem_req_i;

`ifdef MEM_ARB_RR_EN
  logic last_win_q, last_win_d;  // 1 = dmem won the last grant

  assign imem_wins = last_win_q;

  always_comb begin
    last_win_d = last_win_q;
    if (accept) last_win_d = sel_dmem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_win_q <= 1'b1;
    else       last_win_q <= last_win_d;
  end
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign imem_wins = (starve_q == SW'(STARVE_LIMIT));

  // Any dmem grant taken while imem is waiting counts as an imem loss.
  always_comb begin
    starve_d = starve_q;
    if (accept && !sel_dmem)
      starve_d = '0;
    else if (accept && bus.imem_req_i && !imem_wins)
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    sel_valid = 1'b0;
    sel_dmem  = 1'b0;
    case (state_q)
      IDLE: begin
        sel_valid = bus.imem_req_i | bus.dmem_req_i;
        sel_dmem  = contend ? !imem_wins : bus.dmem_req_i;
      end
      LOCK_I: sel_valid = 1'b1;
      LOCK_D: begin
        sel_valid = 1'b1;
        sel_dmem  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are forced low while reset is held, independent of the clock.
    req    = sel_valid & room & ~reset;
    accept = req & bus.mem_gnt_i;
    if (req) state_d = bus.mem_gnt_i ? IDLE : (sel_dmem ? LOCK_D : LOCK_I);
  end

  assign pop  = bus.mem_rvalid_i & (count_q != '0) & ~reset;
  assign head = id_q[rd_ptr_q];

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    resp_err_d = resp_err_q;
    if (accept) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (!accept && pop) count_d = count_q - CW'(1);
    if (bus.mem_rvalid_i && (count_q == '0)) resp_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      resp_err_q <= resp_err_d;
    end
  end

  // ID storage is only meaningful between push and pop, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) id_q[wr_ptr_q] <= sel_dmem;
  end

  assign bus.imem_gnt_o    = accept & ~sel_dmem;
  assign bus.dmem_gnt_o    = accept & sel_dmem;
  assign bus.imem_rvalid_o = pop & ~head;
  assign bus.dmem_rvalid_o = pop & head;
  assign bus.imem_rdata_o  = reset ? 32'h0 : bus.mem_rdata_i;
  assign bus.dmem_rdata_o  = reset ? 32'h0 : bus.mem_rdata_i;

  assign bus.mem_req_o     = req;
  assign bus.mem_addr_o    = !req ? 32'h0 : (sel_dmem ? bus.dmem_addr_i : bus.imem_addr_i);
  assign bus.mem_byte_en_o = !req ? 2'b00 : (sel_dmem ? bus.dmem_byte_en_i : 2'b11);
  assign bus.mem_wr_o      = req & sel_dmem & bus.dmem_wr_i;
  assign bus.mem_wr_data_o = (req & sel_dmem) ? bus.dmem_wr_data_i : 32'h0;
  assign bus.resp_err_o    = resp_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants push expected responses, memory model returns them.
// Grant-order expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_OUTST(4), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          port;   // 0 = imem, 1 = dmem
    logic [31:0] data;
  } exp_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;

  exp_t        exp_q[$];
  int unsigned due_q[$];
  logic [31:0] dat_q[$];
  logic [31:0] data_plan[$];
  logic [31:0] auto_data = 32'h1000_0000;
  bit          gnt_log[$];

  bit          hold = 0;
  int          release_n = 0;
  bit          stray = 0;
  int unsigned lat = 2;
  bit          i_auto = 0, d_auto = 0;
  bit          granted_i = 0, granted_d = 0;
  int          n_gnt = 0;
  int unsigned last_gnt_cyc = 0, last_rsp_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called once per cycle at the falling edge.
  task automatic observe();
    exp_t        e;
    bit          p;
    logic [31:0] d;
    if (bus.mem_rvalid_i) begin
      if (exp_q.size() == 0) begin
        check("stray_irvalid", bus.imem_rvalid_o, 0);
        check("stray_drvalid", bus.dmem_rvalid_o, 0);
        $display("cyc %0d stray rvalid data=0x%08h", cyc, bus.mem_rdata_i);
      end else begin
        e = exp_q.pop_front();
        check("rsp_irvalid", bus.imem_rvalid_o, (e.port == 1'b0));
        check("rsp_drvalid", bus.dmem_rvalid_o, (e.port == 1'b1));
        check("rsp_rdata", e.port ? bus.dmem_rdata_o : bus.imem_rdata_o, e.data);
        last_rsp_cyc = cyc;
        $display("cyc %0d rsp %s data=0x%08h", cyc, e.port ? "dmem" : "imem", e.data);
      end
    end
    if ((bus.mem_req_o && bus.mem_gnt_i) || bus.imem_gnt_o || bus.dmem_gnt_o) begin
      p = bus.dmem_gnt_o;
      check("gnt_onehot", 32'(bus.imem_gnt_o) + 32'(bus.dmem_gnt_o), 1);
      check("gnt_handshake", bus.mem_req_o & bus.mem_gnt_i, 1);
      check("gnt_addr", bus.mem_addr_o, p ? bus.dmem_addr_i : bus.imem_addr_i);
      check("gnt_wr", bus.mem_wr_o, p ? bus.dmem_wr_i : 1'b0);
      if (data_plan.size() != 0) d = data_plan.pop_front();
      else begin
        d = auto_data;
        auto_data = auto_data + 1;
      end
      exp_q.push_back('{port: p, data: d});
      due_q.push_back(cyc + lat);
      dat_q.push_back(d);
      gnt_log.push_back(p);
      n_gnt++;
      last_gnt_cyc = cyc;
      if (p) granted_d = 1; else granted_i = 1;
    end
  endtask

  task automatic drive_mem();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    if (stray) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'h5A5A_5A5A;
      stray = 0;
    end else if (due_q.size() != 0 && ((!hold && due_q[0] <= cyc) || release_n > 0)) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = dat_q.pop_front();
      due_q.delete(0);
      if (release_n > 0) release_n--;
    end
  endtask

  task automatic step();
    granted_i = 0;
    granted_d = 0;
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc++;
    #1;
    drive_mem();
    if (granted_i && i_auto) bus.imem_addr_i = bus.imem_addr_i + 32'd4;
    if (granted_d && d_auto) begin
      bus.dmem_addr_i = bus.dmem_addr_i + 32'd4;
      bus.dmem_wr_i   = ~bus.dmem_wr_i;
    end
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((exp_q.size() != 0 || due_q.size() != 0) && k < max) begin
      step();
      k++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic clear_inputs();
    bus.imem_req_i = 0; bus.imem_addr_i = 0;
    bus.dmem_req_i = 0; bus.dmem_addr_i = 0; bus.dmem_byte_en_i = 0;
    bus.dmem_wr_i = 0; bus.dmem_wr_data_i = 0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_ctrl", {bus.imem_gnt_o, bus.dmem_gnt_o, bus.imem_rvalid_o, bus.dmem_rvalid_o,
                       bus.mem_req_o, bus.mem_wr_o, bus.resp_err_o, bus.mem_byte_en_o}, 0);
    check("rst_addr", bus.mem_addr_o, 0);
    check("rst_wdata", bus.mem_wr_data_o, 0);
    check("rst_irdata", bus.imem_rdata_o, 0);
    check("rst_drdata", bus.dmem_rdata_o, 0);
    exp_q.delete(); due_q.delete(); dat_q.delete(); data_plan.delete(); gnt_log.delete();
    i_auto = 0; d_auto = 0; hold = 0; release_n = 0; stray = 0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst_err_clear", bus.resp_err_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_p;
    reset = 1'b1;
    clear_inputs();
    do_reset();

    // Lone fetch: same-cycle grant, response two cycles later
    lat = 2;
    data_plan.push_back(32'h0050_0093);
    bus.imem_req_i = 1; bus.imem_addr_i = 32'h100; bus.mem_gnt_i = 1;
    #2;
    check("t1_igrant", bus.imem_gnt_o, 1);
    check("t1_addr", bus.mem_addr_o, 32'h100);
    check("t1_wr", bus.mem_wr_o, 0);
    step();
    bus.imem_req_i = 0;
    drain(10);
    check("t1_latency", last_rsp_cyc - last_gnt_cyc, 2);

    // Lock: dmem store stalled by memory, imem must wait
    bus.mem_gnt_i = 0;
    bus.dmem_req_i = 1; bus.dmem_addr_i = 32'h2000; bus.dmem_wr_i = 1;
    bus.dmem_wr_data_i = 32'hCAFE_F00D; bus.dmem_byte_en_i = 2'd3;
    for (int k = 1; k <= 3; k++) begin
      #2;
      check("t2_req", bus.mem_req_o, 1);
      check("t2_addr", bus.mem_addr_o, 32'h2000);
      check("t2_wr", bus.mem_wr_o, 1);
      check("t2_gnts", {bus.imem_gnt_o, bus.dmem_gnt_o}, 0);
      step();
      if (k == 1) begin
        bus.imem_req_i = 1; bus.imem_addr_i = 32'h104;
      end
    end
    bus.mem_gnt_i = 1;
    #2;
    check("t2_dgrant", bus.dmem_gnt_o, 1);
    check("t2_ihold", bus.imem_gnt_o, 0);
    check("t2_wdata", bus.mem_wr_data_o, 32'hCAFE_F00D);
    step();
    bus.dmem_req_i = 0; bus.dmem_wr_i = 0;
    #2;
    check("t2_inext", bus.imem_gnt_o, 1);
    check("t2_iaddr", bus.mem_addr_o, 32'h104);
    step();
    bus.imem_req_i = 0;
    drain(10);

    // Backpressure at MAX_OUTST = 4
    hold = 1; lat = 1; i_auto = 1; d_auto = 1;
    bus.imem_req_i = 1; bus.dmem_req_i = 1;
    n_gnt = 0;
    repeat (8) step();
    check("t3_fill", n_gnt, 4);
    #2 check("t3_blocked", bus.mem_req_o, 0);
    n_gnt = 0; release_n = 1;
    repeat (4) step();
    check("t3_reopen_one", n_gnt, 1);
    n_gnt = 0; release_n = 2;
    repeat (5) step();
    check("t3_push_pop", n_gnt, 2);
    #2 check("t3_blocked2", bus.mem_req_o, 0);
    i_auto = 0; d_auto = 0; bus.imem_req_i = 0; bus.dmem_req_i = 0; hold = 0;
    drain(30);

    // Reset with two transactions outstanding
    hold = 1;
    bus.mem_gnt_i = 1;
    bus.imem_req_i = 1; bus.imem_addr_i = 32'h200;
    step();
    bus.imem_req_i = 0; bus.dmem_req_i = 1; bus.dmem_addr_i = 32'h3000;
    step();
    check("t6_pending", exp_q.size(), 2);
    bus.imem_req_i = 1; bus.dmem_req_i = 1; bus.dmem_wr_i = 1; bus.dmem_wr_data_i = 32'h1234_5678;
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hFFFF_FFFF;
    do_reset();
    bus.mem_gnt_i = 1; hold = 1; lat = 1; i_auto = 1; d_auto = 1;
    bus.imem_req_i = 1; bus.dmem_req_i = 1;
    n_gnt = 0;
    repeat (8) step();
    check("t6_fill_after_reset", n_gnt, 4);
    i_auto = 0; d_auto = 0; bus.imem_req_i = 0; bus.dmem_req_i = 0; hold = 0;
    drain(30);

    // Starvation / round-robin grant order under continuous contention
    do_reset();
    bus.mem_gnt_i = 1; lat = 1; i_auto = 1; d_auto = 1;
    bus.imem_req_i = 1; bus.imem_addr_i = 32'h400;
    bus.dmem_req_i = 1; bus.dmem_addr_i = 32'h5000;
    repeat (14) step();
    check("t4_enough", gnt_log.size() >= 12, 1);
    for (int k = 0; k < 12 && k < gnt_log.size(); k++) begin
`ifdef MEM_ARB_RR_EN
      exp_p = (k % 2 == 0) ? 1'b0 : 1'b1;
`else
      exp_p = (k % 4 == 3) ? 1'b0 : 1'b1;
`endif
      check($sformatf("t4_order%0d", k), gnt_log[k], exp_p);
    end
    i_auto = 0; d_auto = 0; bus.imem_req_i = 0; bus.dmem_req_i = 0;
    drain(20);

    // In-order routing of I, D, I then a stray response
    gnt_log.delete();
    lat = 3;
    data_plan.push_back(32'hA); data_plan.push_back(32'hB); data_plan.push_back(32'hC);
    bus.imem_req_i = 1; bus.imem_addr_i = 32'h300;
    step();
    bus.imem_req_i = 0; bus.dmem_req_i = 1; bus.dmem_addr_i = 32'h4000; bus.dmem_wr_i = 0;
    step();
    bus.dmem_req_i = 0; bus.imem_req_i = 1; bus.imem_addr_i = 32'h304;
    step();
    bus.imem_req_i = 0;
    drain(20);
    check("t5_ngrants", gnt_log.size(), 3);
    if (gnt_log.size() == 3) begin
      check("t5_g0", gnt_log[0], 0);
      check("t5_g1", gnt_log[1], 1);
      check("t5_g2", gnt_log[2], 0);
    end
    check("t5_err_before", bus.resp_err_o, 0);
    stray = 1;
    step();
    step();
    check("t5_err_after", bus.resp_err_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
